// File: rtl/play_judge_pkg.sv
// play_judge shared constants: grade encoding, base points, default windows.
package play_judge_pkg;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_PERFECT = 2'd2
  } grade_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PTS_PERFECT = 3;
  localparam int PTS_GOOD    = 1;
  localparam int PTS_MISS    = 0;

  localparam int DEF_WIN_PERFECT = 3;
  localparam int DEF_WIN_GOOD    = 8;

endpackage

// File: rtl/play_judge_if.sv
// Chart-note handshake and key-hit bundle between sequencer and judge.
interface play_judge_if #(
  parameter int LANES  = 7,
  parameter int TIME_W = 20
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic              note_valid;
  logic              note_ready;
  logic [LW-1:0]     note_lane;
  logic [TIME_W-1:0] note_time;
  logic              note_last;
  logic              hit_valid;
  logic [LW-1:0]     hit_lane;

  modport master (
    output note_valid, note_lane, note_time, note_last,
    output hit_valid, hit_lane,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_lane, note_time, note_last,
    input  hit_valid, hit_lane,
    output note_ready
  );
endinterface

// File: rtl/judge_fifo.sv
// Pending-note FIFO of {lane, time, last}; same-cycle push and pop.
module judge_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr;
  logic [AW:0]  rd;

  assign empty = (wr == rd);
  assign full  = (wr[AW] != rd[AW]) &&
                 (wr[AW-1:0] == rd[AW-1:0]);
  assign dout  = mem[rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  end
endmodule

// File: rtl/play_judge.sv
// Rhythm-game judgement engine: grades hits against the oldest pending note.
// PLAY_JUDGE_COMBO_BONUS_EN adds combo>>3 bonus points per PERFECT/GOOD.
module play_judge
  import play_judge_pkg::*;
#(
  parameter int LANES       = 7,
  parameter int TIME_W      = 20,
  parameter int WIN_PERFECT = DEF_WIN_PERFECT,
  parameter int WIN_GOOD    = DEF_WIN_GOOD,
  parameter int DEPTH       = 4,
  parameter int SCORE_W     = 21,
  parameter int COMBO_W     = 10,
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               tick,
  play_judge_if.slave        bus,
  output logic               judge_valid,
  output logic [1:0]         judge_grade,
  output logic [LW-1:0]      judge_lane,
  output logic [LANES-1:0]   lane_led,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic [COMBO_W-1:0] max_combo,
  output logic [COMBO_W-1:0] n_perfect,
  output logic [COMBO_W-1:0] n_good,
  output logic [COMBO_W-1:0] n_miss,
  output logic               done
);
  localparam int FW = LW + TIME_W + 1;
  localparam int DW = TIME_W + 2;
  localparam int AW = ((SCORE_W > COMBO_W) ? SCORE_W : COMBO_W) + 2;

  state_e              state;
  logic [TIME_W-1:0]   now;
  logic                last_popped;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [FW-1:0]       head;
  logic [LW-1:0]       h_lane;
  logic [TIME_W-1:0]   h_time;
  logic                h_last;
  logic signed [DW-1:0] d;
  logic signed [DW-1:0] wg;
  logic signed [DW-1:0] wp;
  logic                active;
  logic                in_good;
  logic                is_perf;
  logic                hit_ok;
  logic                miss;
  logic [AW-1:0]       add;
  logic [AW-1:0]       sum;
  logic [SCORE_W-1:0]  score_nx;
  logic [COMBO_W-1:0]  combo_nx;

  judge_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({bus.note_lane, bus.note_time, bus.note_last}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign {h_lane, h_time, h_last} = head;
  assign bus.note_ready = !full;
  assign push = bus.note_valid && !full && en && (state != DONE);

  // Two guard bits keep the offset exact for any in-range note time.
  assign wg = DW'(WIN_GOOD);
  assign wp = DW'(WIN_PERFECT);
  assign d  = $signed({2'b00, now}) - $signed({2'b00, h_time});

  assign in_good = (d >= -wg) && (d <= wg);
  assign is_perf = (d >= -wp) && (d <= wp);
  assign active  = en && (state == RUN) && !empty;
  assign hit_ok  = active && bus.hit_valid &&
                   (bus.hit_lane == h_lane) && in_good;
  assign miss    = active && !hit_ok && (d > wg);
  assign pop     = hit_ok || miss;

  always_comb begin
    add = is_perf ? AW'(PTS_PERFECT) : AW'(PTS_GOOD);
`ifdef PLAY_JUDGE_COMBO_BONUS_EN
    add = add + AW'(combo >> 3);
`else
    add = add + AW'(PTS_MISS);
`endif
    sum = AW'(score) + add;
    score_nx = (sum > AW'({SCORE_W{1'b1}})) ?
               {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    combo_nx = (&combo) ? combo : combo + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      now         <= '0;
      last_popped <= 1'b0;
      judge_valid <= 1'b0;
      judge_grade <= '0;
      judge_lane  <= '0;
      lane_led    <= '0;
      score       <= '0;
      combo       <= '0;
      max_combo   <= '0;
      n_perfect   <= '0;
      n_good      <= '0;
      n_miss      <= '0;
      done        <= 1'b0;
    end else begin
      judge_valid <= 1'b0;
      lane_led    <= (state == RUN && !empty && in_good) ?
                     (LANES'(1) << h_lane) : '0;
      if (state == IDLE)
        now <= '0;
      else if (state == RUN && en && tick)
        now <= now + 1'b1;
      if (pop) begin
        judge_valid <= 1'b1;
        judge_lane  <= h_lane;
        last_popped <= last_popped | h_last;
      end
      if (hit_ok) begin
        judge_grade <= is_perf ? GRADE_PERFECT : GRADE_GOOD;
        score       <= score_nx;
        combo       <= combo_nx;
        if (combo_nx > max_combo) max_combo <= combo_nx;
        if (is_perf) begin
          if (!(&n_perfect)) n_perfect <= n_perfect + 1'b1;
        end else begin
          if (!(&n_good)) n_good <= n_good + 1'b1;
        end
      end else if (miss) begin
        judge_grade <= GRADE_MISS;
        combo       <= '0;
        if (!(&n_miss)) n_miss <= n_miss + 1'b1;
      end
      case (state)
        IDLE: if (push) state <= RUN;
        RUN: begin
          if (last_popped && empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_play_judge.sv
// Directed bench for play_judge; a second SCORE_W=4 copy checks saturation.
module tb_play_judge;
  import play_judge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic tick;

  always #5 clk = ~clk;

  play_judge_if #(.LANES(7), .TIME_W(20)) bus ();
  play_judge_if #(.LANES(7), .TIME_W(20)) bus2 ();

  assign bus2.note_valid = bus.note_valid;
  assign bus2.note_lane  = bus.note_lane;
  assign bus2.note_time  = bus.note_time;
  assign bus2.note_last  = bus.note_last;
  assign bus2.hit_valid  = bus.hit_valid;
  assign bus2.hit_lane   = bus.hit_lane;

  logic        jv, jv2;
  logic [1:0]  jg, jg2;
  logic [2:0]  jl, jl2;
  logic [6:0]  led, led2;
  logic [20:0] score;
  logic [3:0]  score2;
  logic [9:0]  combo, combo2, maxc, maxc2;
  logic [9:0]  np, np2, ng, ng2, nm, nm2;
  logic        done, done2;

  play_judge dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .bus(bus),
    .judge_valid(jv), .judge_grade(jg), .judge_lane(jl),
    .lane_led(led), .score(score), .combo(combo),
    .max_combo(maxc), .n_perfect(np), .n_good(ng),
    .n_miss(nm), .done(done)
  );

  play_judge #(.SCORE_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .bus(bus2),
    .judge_valid(jv2), .judge_grade(jg2), .judge_lane(jl2),
    .lane_led(led2), .score(score2), .combo(combo2),
    .max_combo(maxc2), .n_perfect(np2), .n_good(ng2),
    .n_miss(nm2), .done(done2)
  );

  int checks   = 0;
  int failures = 0;
  int now_m    = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic adv_to(input int t);
    tick = 1'b1;
    while (now_m < t) begin
      cyc();
      now_m++;
    end
    tick = 1'b0;
  endtask

  task automatic push(input int lane, input int t, input bit last);
    int k;
    bus.note_valid = 1'b1;
    bus.note_lane  = 3'(lane);
    bus.note_time  = 20'(t);
    bus.note_last  = last;
    k = 0;
    while (!bus.note_ready && k < 20) begin
      cyc();
      k++;
    end
    if (!bus.note_ready) check("push_ready", 32'(bus.note_ready), 1);
    cyc();
    bus.note_valid = 1'b0;
    bus.note_last  = 1'b0;
  endtask

  task automatic hit(input int lane);
    bus.hit_valid = 1'b1;
    bus.hit_lane  = 3'(lane);
    cyc();
    bus.hit_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int strobes;
    int okcnt;
    int exp_score;
`ifdef PLAY_JUDGE_COMBO_BONUS_EN
    exp_score = 76;
`else
    exp_score = 60;
`endif
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    bus.note_valid = 1'b0; bus.note_lane = '0;
    bus.note_time = '0; bus.note_last = 1'b0;
    bus.hit_valid = 1'b0; bus.hit_lane = '0;
    repeat (3) cyc();
    check("rst_ready", 32'(bus.note_ready), 1);
    check("rst_score", 32'(score), 0);
    check("rst_jv", 32'(jv), 0);
    check("rst_done", 32'(done), 0);
    rst = 1'b0;
    en  = 1'b1;

    push(2, 100, 1'b0);
    adv_to(101);
    check("led_in_win", 32'(led), 4);
    hit(2);
    check("perf_jv", 32'(jv), 1);
    check("perf_grade", 32'(jg), 2);
    check("perf_lane", 32'(jl), 2);
    check("perf_score", 32'(score), 3);
    check("perf_combo", 32'(combo), 1);
    check("sat_score_small", 32'(score2), 3);

    push(3, 200, 1'b0);
    adv_to(190);
    hit(3);
    check("early_ignored", 32'(jv), 0);
    adv_to(195);
    hit(3);
    check("good_jv", 32'(jv), 1);
    check("good_grade", 32'(jg), 1);
    check("good_score", 32'(score), 4);
    check("good_combo", 32'(combo), 2);
    push(4, 300, 1'b0);
    adv_to(300);
    hit(1);
    check("wrong_lane_ignored", 32'(jv), 0);
    hit(4);
    check("perf2_grade", 32'(jg), 2);
    check("perf2_score", 32'(score), 7);

    push(0, 400, 1'b0);
    adv_to(408);
    cyc();
    check("no_miss_at_d8", 32'(jv), 0);
    adv_to(409);
    check("miss_not_yet", 32'(jv), 0);
    cyc();
    check("miss_jv", 32'(jv), 1);
    check("miss_grade", 32'(jg), 0);
    check("miss_lane", 32'(jl), 0);
    check("miss_combo", 32'(combo), 0);
    check("miss_count", 32'(nm), 1);
    check("miss_maxc", 32'(maxc), 3);
    check("miss_score", 32'(score), 7);
    cyc();
    check("miss_single", 32'(jv), 0);
    check("miss_popped_led", 32'(led), 0);

    push(1, 500, 1'b0);
    adv_to(495);
    en = 1'b0;
    tick = 1'b1;
    strobes = 0;
    bus.hit_valid = 1'b1;
    bus.hit_lane  = 3'd1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      bus.hit_valid = 1'b0;
      if (jv) strobes++;
    end
    tick = 1'b0;
    en = 1'b1;
    check("en_low_no_strobe", 32'(strobes), 0);
    hit(1);
    check("frozen_good_jv", 32'(jv), 1);
    check("frozen_good_grade", 32'(jg), 1);
    check("frozen_score", 32'(score), 8);
    check("frozen_n_good", 32'(ng), 2);

    push(2, 500, 1'b0);
    adv_to(496);
    check("led_before_rst", 32'(led), 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    now_m = 0;
    check("midrst_score", 32'(score), 0);
    check("midrst_combo", 32'(combo), 0);
    check("midrst_maxc", 32'(maxc), 0);
    check("midrst_counts", 32'(np) + 32'(ng) + 32'(nm), 0);
    check("midrst_led", 32'(led), 0);
    check("midrst_ready", 32'(bus.note_ready), 1);

    for (int i = 0; i < 4; i++) push(i % 7, 20 * (i + 1), 1'b0);
    check("full_not_ready", 32'(bus.note_ready), 0);
    okcnt = 0;
    for (int i = 0; i < 20; i++) begin
      adv_to(20 * (i + 1));
      hit(i % 7);
      if (jv && jg == 2'd2) okcnt++;
      if (i + 4 < 20) push((i + 4) % 7, 20 * (i + 5), (i + 4) == 19);
    end
    check("run_perfects", 32'(okcnt), 20);
    check("run_score", 32'(score), 32'(exp_score));
    check("run_combo", 32'(combo), 20);
    check("run_maxc", 32'(maxc), 20);
    check("run_n_perfect", 32'(np), 20);
    check("sat_score", 32'(score2), 15);
    check("done_not_yet", 32'(done), 0);
    cyc();
    check("done_set", 32'(done), 1);
    repeat (5) cyc();
    check("done_held", 32'(done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/play_judge.md
# play_judge

Parametrised multi-lane rhythm-game judgement engine, next generation of the single-note play mode. It accepts a time-stamped chart note stream from the song sequencer through a valid/ready handshake and buffers upcoming notes in a small FIFO. Each player hit is graded PERFECT/GOOD against the oldest pending note, and unhit notes are graded MISS once their window expires. It keeps score, combo, max combo and grade counters for the scoreboard and level LEDs.

## Interface
Parameters:
- LANES, 7: number of note lanes/keys.
- TIME_W, 20: width of play-time counter and note timestamps.
- WIN_PERFECT, 3: half-window (ticks) for PERFECT.
- WIN_GOOD, 8: half-window (ticks) for GOOD. Requires WIN_GOOD ≥ WIN_PERFECT.
- DEPTH, 4: pending-note FIFO depth, power of two.
- SCORE_W, 21: score width. Saturating.
- COMBO_W, 10: combo and counter width. Saturating.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  play mode active. Low freezes time and ignores hits and chart input.
- tick  in  1  one-cycle time-base pulse.
- note_valid  in  1  chart note offered.
- note_ready  out  1  equals !full.
- note_lane  in  $clog2(LANES)  lane of the offered note.
- note_time  in  TIME_W  target tick of the offered note.
- note_last  in  1  offered note is the final chart note.
- hit_valid  in  1  one-cycle key-press pulse, already debounced.
- hit_lane  in  $clog2(LANES)  lane that was pressed.
- judge_valid  out  1  one-cycle grade strobe.
- judge_grade  out  2  0 MISS, 1 GOOD, 2 PERFECT.
- judge_lane  out  $clog2(LANES)  lane of the graded note.
- lane_led  out  LANES  one-hot of the head note's lane while it is inside the GOOD window.
- score  out  SCORE_W  accumulated score.
- combo  out  COMBO_W  current combo.
- max_combo  out  COMBO_W  best combo.
- n_perfect, n_good, n_miss  out  COMBO_W each  grade counts.
- done  out  1  chart finished, level high until rst.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on the first accepted note.
  - RUN → DONE when the last note has been accepted and the FIFO has drained.
- Play time `now` clears in IDLE. It increments on tick only when en and RUN, and wraps modulo 2^TIME_W. Charts must never span a wrap.
- Chart push happens when note_valid & note_ready & en. A note arriving in DONE is ignored.
- Only the FIFO head note is judged. Signed offset d = now − head.time.
  - Hit on the head lane with |d| ≤ WIN_PERFECT → PERFECT.
  - Hit on the head lane with |d| ≤ WIN_GOOD → GOOD.
  - Hit with d < −WIN_GOOD, on a wrong lane, or with the FIFO empty → ignored, no judge strobe.
  - When d > WIN_GOOD and no hit is being graded → MISS.
  - Each grade pops the head note.
- Score update: PERFECT +3, GOOD +1, MISS +0.
- Combo update: PERFECT or GOOD increments combo. MISS clears combo.
- max_combo = max(max_combo, new combo).
- All counters saturate at their all-ones value.
- Simultaneous events:
  - Hit and tick in the same cycle: the hit is judged against the pre-increment now.
  - Push and pop in the same cycle: both occur. note_ready still reflects the pre-pop full flag.
- en deasserted mid-play: all state is held, hits are ignored, no MISS is generated.
- rst mid-play: every register clears next edge.

## Timing
- Reset values: all outputs 0. note_ready is 1 because the FIFO is empty.
- Hit-to-grade latency: judge_valid/grade/lane appear 1 cycle after the hit_valid cycle.
- Updated score, combo and counters appear in that same cycle.
- MISS strobe asserts 1 cycle after the cycle in which d first exceeds WIN_GOOD.
- At most one grade per cycle.
- lane_led and done are registered and update 1 cycle after the condition changes.

## Configuration
- PLAY_JUDGE_COMBO_BONUS_EN defined: each PERFECT/GOOD adds an extra combo>>3 to score, using the pre-increment combo, saturating.
- Macro undefined: no bonus; score is base points only.

## Structure
- Shared constants header holds:
  - grade encoding (GRADE_MISS, GRADE_GOOD, GRADE_PERFECT);
  - base point values;
  - default window widths.
- One sub-module, `judge_fifo`: a synchronous FIFO of {lane, time, last} with full/empty flags and same-cycle push/pop.
- Grading, scoring and the FSM live in play_judge.

## Test plan
- Perfect hit: note lane 2 at t=100; hit lane 2 at now=101 → judge_grade=2, score=3, combo=1 one cycle later.
- Good and ignores:
  - hit at now=95 → GOOD;
  - hit at now=90 → no strobe;
  - wrong-lane hit at now=100 → no strobe.
- Miss: no hit for a note at t=100 → MISS strobe at now=109; combo=0; n_miss=1; head popped.
- Combo and backpressure: 20 consecutive PERFECTs with the FIFO full → note_ready low while full; max_combo=20; score=60, or 60+bonus sum with PLAY_JUDGE_COMBO_BONUS_EN.
- Control events:
  - en low for 50 ticks mid-chart → now frozen, no MISS;
  - rst mid-play → all outputs 0 next cycle.
- Finish: last note graded → done=1 and held; saturating score test with SCORE_W=4 → score sticks at 15.
